// File: rtl/seq_uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings, default
// serial settings and the sequencer opcode fields used to build test programs.
package seq_uart_loader_pkg;

   // Default system clock and serial rate; together they give 100 clocks per bit.
   localparam int DEFAULT_CLK_FREQ = 100_000_000;
   localparam int DEFAULT_BAUD     = 1_000_000;

   // Receiver states: wait for a start edge, qualify it, shift data, check stop.
   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_t;

   // Loader states: expect a count byte, collect words, wait for the FIFO to drain.
   typedef enum logic [1:0] {
      L_COUNT = 2'd0,
      L_LOAD  = 2'd1,
      L_DRAIN = 2'd2
   } ld_state_t;

   // Sequencer instruction format: opcode in bits [7:6], operand in [5:0].
   // The loader itself never decodes these; they only help build programs.
   localparam logic [1:0] seq_op_ld  = 2'b00;
   localparam logic [1:0] seq_op_add = 2'b01;
   localparam logic [1:0] seq_op_jmp = 2'b10;
   localparam logic [1:0] seq_op_out = 2'b11;

   // Pack an opcode and operand into one instruction word.
   function automatic logic [7:0] seq_inst(input logic [1:0] op, input logic [5:0] arg);
      return {op, arg};
   endfunction

endpackage

// File: rtl/seq_uart_loader_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit qualification at mid-bit,
// LSB-first data capture and stop-bit check. byte_vld and frm_err are
// single-cycle strobes raised in the cycle the stop bit is sampled.
module uart_rx_core
   import seq_uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 100
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_wd,
   output logic       byte_vld,
   output logic       frm_err
);

   localparam int                CNT_W   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_meta_q;
   logic             rx_sync_q;
   logic             rx_prev_q;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;

   // Bring rx into the clock domain; idle line level is high, so reset to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Receiver next-state logic; the baud counter restarts on every bit boundary.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      byte_vld = 1'b0;
      frm_err  = 1'b0;
      unique case (state_q)
         R_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            // Only a high-to-low transition starts a frame, so a line held
            // low after a framing error does not retrigger.
            if (!rx_sync_q && rx_prev_q) begin
               state_d = R_START;
            end
         end
         R_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               // Still low at mid-bit: a real start bit. Otherwise a glitch.
               state_d = rx_sync_q ? R_IDLE : R_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         R_DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = R_STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         R_STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = '0;
               state_d = R_IDLE;
               if (rx_sync_q) begin
                  byte_vld = 1'b1;
               end else begin
                  frm_err  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = R_IDLE;
         end
      endcase
   end

   // Receiver state, baud counter, bit index and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= R_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // All eight data bits are in place by the time the stop bit is sampled.
   assign byte_wd = shift_q;

endmodule

// File: rtl/seq_uart_loader.sv
// Serial program loader for the sequencer. A count byte N is followed by N
// instruction bytes; the words are buffered in a FIFO and handed to the
// sequencer one per inst_vld strobe, spaced by ISSUE_GAP and held off by
// inst_busy. prog_done pulses once the last word of a program has gone out.
module seq_uart_loader
   import seq_uart_loader_pkg::*;
#(
   parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
   parameter int BAUD      = DEFAULT_BAUD,
   parameter int DEPTH     = 16,   // power of 2, at least 2
   parameter int ISSUE_GAP = 4
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       inst_busy,
   output logic [7:0] inst_wd,
   output logic       inst_vld,
   output logic       prog_done,
   output logic       frm_err,
   output logic       ovf_err
);

   localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int               AW           = $clog2(DEPTH);
   localparam int               PW           = AW + 1;
   localparam int               GAP_W        = $clog2(ISSUE_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_RELOAD   = GAP_W'(ISSUE_GAP - 1);

   // Receiver outputs
   logic [7:0]       byte_wd;
   logic             byte_vld;
   logic             rx_frm_err;

   // Loader and FIFO state
   ld_state_t        ld_state_q, ld_state_d;
   logic [7:0]       remain_q, remain_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]       mem [DEPTH];
   logic [GAP_W-1:0] gap_q, gap_d;

   // Registered outputs
   logic [7:0]       inst_wd_q, inst_wd_d;
   logic             inst_vld_q, inst_vld_d;
   logic             prog_done_q, prog_done_d;
   logic             frm_err_q, frm_err_d;
   logic             ovf_err_q, ovf_err_d;

   logic             fifo_empty;
   logic             fifo_full;
   logic             issue;
   logic             push;

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .byte_wd  (byte_wd),
      .byte_vld (byte_vld),
      .frm_err  (rx_frm_err)
   );

   // FIFO flags: the extra pointer MSB separates full from empty.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   end

   // Issue path: pop one word when data is waiting, the sequencer is free
   // and the spacing counter has run out. Independent of the loader state.
   always_comb begin
      issue      = !fifo_empty && !inst_busy && (gap_q == '0);
      rd_ptr_d   = rd_ptr_q;
      gap_d      = gap_q;
      inst_wd_d  = inst_wd_q;
      inst_vld_d = 1'b0;
      if (issue) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         gap_d      = GAP_RELOAD;
         inst_vld_d = 1'b1;
         inst_wd_d  = mem[rd_ptr_q[AW-1:0]];
      end else if (gap_q != '0) begin
         gap_d = gap_q - 1'b1;
      end
   end

   // Loader FSM: frames the byte stream into count + words and drives pushes.
   always_comb begin
      ld_state_d  = ld_state_q;
      remain_d    = remain_q;
      push        = 1'b0;
      ovf_err_d   = 1'b0;
      prog_done_d = 1'b0;
      unique case (ld_state_q)
         L_COUNT: begin
            // A zero count is meaningless and is simply skipped.
            if (byte_vld && (byte_wd != 8'h00)) begin
               remain_d   = byte_wd;
               ld_state_d = L_LOAD;
            end
         end
         L_LOAD: begin
            if (byte_vld) begin
               // A pop in the same cycle frees a slot even when full.
               if (!fifo_full || issue) begin
                  push = 1'b1;
               end else begin
                  ovf_err_d = 1'b1;
               end
               // Count the byte either way so we stay aligned with the host.
               remain_d = remain_q - 8'd1;
               if (remain_q == 8'd1) begin
                  ld_state_d = L_DRAIN;
               end
            end
         end
         L_DRAIN: begin
            // Bytes arriving before the program has finished are not a new count.
            if (byte_vld) begin
               ovf_err_d = 1'b1;
            end
            // Empty FIFO means the last pop happened in an earlier cycle,
            // so this lands one cycle after its inst_vld.
            if (fifo_empty) begin
               prog_done_d = 1'b1;
               ld_state_d  = L_COUNT;
            end
         end
         default: begin
            ld_state_d = L_COUNT;
         end
      endcase
      wr_ptr_d  = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
      frm_err_d = rx_frm_err;
   end

   // FIFO storage; no reset so it maps onto RAM. Pointers alone define contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= byte_wd;
      end
   end

   // Loader, FIFO pointer, spacing counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_state_q  <= L_COUNT;
         remain_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         gap_q       <= '0;
         inst_wd_q   <= 8'h00;
         inst_vld_q  <= 1'b0;
         prog_done_q <= 1'b0;
         frm_err_q   <= 1'b0;
         ovf_err_q   <= 1'b0;
      end else begin
         ld_state_q  <= ld_state_d;
         remain_q    <= remain_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         gap_q       <= gap_d;
         inst_wd_q   <= inst_wd_d;
         inst_vld_q  <= inst_vld_d;
         prog_done_q <= prog_done_d;
         frm_err_q   <= frm_err_d;
         ovf_err_q   <= ovf_err_d;
      end
   end

   assign inst_wd   = inst_wd_q;
   assign inst_vld  = inst_vld_q;
   assign prog_done = prog_done_q;
   assign frm_err   = frm_err_q;
   assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_seq_uart_loader.sv
// Bench for seq_uart_loader: serial driver, event monitor, table of programs,
// hand-written overflow / drain / reset sequences and random programs.
module tb_seq_uart_loader;
   import seq_uart_loader_pkg::*;

   localparam int CLK_FREQ  = DEFAULT_CLK_FREQ;
   localparam int BAUD      = DEFAULT_BAUD;
   localparam int DEPTH     = 16;
   localparam int ISSUE_GAP = 4;
   localparam int CPB       = CLK_FREQ / BAUD;
   localparam int TIMEOUT   = 6000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       inst_busy = 1'b0;
   logic [7:0] inst_wd;
   logic       inst_vld;
   logic       prog_done;
   logic       frm_err;
   logic       ovf_err;

   int checks = 0;
   int failures = 0;

   seq_uart_loader #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .DEPTH     (DEPTH),
      .ISSUE_GAP (ISSUE_GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .inst_busy (inst_busy),
      .inst_wd   (inst_wd),
      .inst_vld  (inst_vld),
      .prog_done (prog_done),
      .frm_err   (frm_err),
      .ovf_err   (ovf_err)
   );

   always #5 clk = ~clk;

   // ---------------- monitor: logs events on the falling edge ----------------
   typedef struct {
      int         cyc;
      logic [7:0] wd;
      logic       busy_prev;
   } vld_ev_t;

   vld_ev_t vld_log[$];
   int      done_log[$];
   int      frm_total = 0;
   int      ovf_total = 0;
   int      cyc = 0;

   initial begin
      logic    busy_last;
      vld_ev_t ev;
      busy_last = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (inst_vld) begin
            ev.cyc = cyc;
            ev.wd = inst_wd;
            ev.busy_prev = busy_last;
            vld_log.push_back(ev);
         end
         if (prog_done) done_log.push_back(cyc);
         if (frm_err) frm_total++;
         if (ovf_err) ovf_total++;
         busy_last = inst_busy;
      end
   end

   // ---------------- busy driver: 0 idle, 1 held, 2 random, 3 10us after issue ----------------
   int busy_mode = 0;
   initial begin
      int hold;
      hold = 0;
      forever begin
         @(posedge clk);
         #1;
         case (busy_mode)
            0: begin inst_busy = 1'b0; hold = 0; end
            1: begin inst_busy = 1'b1; hold = 0; end
            2: begin inst_busy = ($urandom_range(0, 3) == 0); hold = 0; end
            default: begin
               if (inst_vld) hold = 1000;
               if (hold > 0) begin
                  inst_busy = 1'b1;
                  hold--;
               end else begin
                  inst_busy = 1'b0;
               end
            end
         endcase
      end
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish within 200000 cycles");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   logic [7:0] exp_w[$];
   int exp_done, exp_frm, exp_ovf;
   int base_v, base_d, base_f, base_o;

   task automatic check_eq(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      logic [9:0] frame;
      frame = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 rx = frame[i];
         repeat (CPB - 1) @(posedge clk);
      end
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (CPB - 1) @(posedge clk);
   endtask

   task automatic snapshot();
      base_v = vld_log.size();
      base_d = done_log.size();
      base_f = frm_total;
      base_o = ovf_total;
   endtask

   task automatic check_reset_outputs(input string name);
      check_eq({name, " inst_wd"}, int'(inst_wd), 0);
      check_eq({name, " inst_vld"}, int'(inst_vld), 0);
      check_eq({name, " prog_done"}, int'(prog_done), 0);
      check_eq({name, " frm_err"}, int'(frm_err), 0);
      check_eq({name, " ovf_err"}, int'(ovf_err), 0);
   endtask

   // Wait for the expected issues and prog_done, then compare against the model.
   task automatic wait_and_check(input string name);
      int waited, n_v, n_d, last_cyc;
      waited = 0;
      while (((vld_log.size() - base_v) < exp_w.size() || (done_log.size() - base_d) < exp_done)
             && waited < TIMEOUT) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= TIMEOUT) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: issues=%0d expected=%0d done=%0d expected=%0d", name,
                  vld_log.size() - base_v, exp_w.size(), done_log.size() - base_d, exp_done);
      end
      repeat (50) @(negedge clk);
      n_v = vld_log.size() - base_v;
      n_d = done_log.size() - base_d;
      check_eq({name, " issue_count"}, n_v, exp_w.size());
      for (int i = 0; i < n_v && i < exp_w.size(); i++)
         check_eq($sformatf("%s word%0d", name, i), int'(vld_log[base_v + i].wd), int'(exp_w[i]));
      for (int i = 0; i < n_v; i++) begin
         check_eq($sformatf("%s busy_at_issue%0d", name, i), int'(vld_log[base_v + i].busy_prev), 0);
         if (i > 0)
            check_eq($sformatf("%s gap_ok%0d(gap=%0d)", name, i,
                               vld_log[base_v + i].cyc - vld_log[base_v + i - 1].cyc),
                     int'((vld_log[base_v + i].cyc - vld_log[base_v + i - 1].cyc) >= ISSUE_GAP), 1);
      end
      check_eq({name, " prog_done_count"}, n_d, exp_done);
      last_cyc = (n_v > 0) ? vld_log[base_v + n_v - 1].cyc : -1000;
      for (int j = 0; j < n_d; j++)
         check_eq({name, " prog_done_lag"}, done_log[base_d + j] - last_cyc, 1);
      check_eq({name, " frm_err_count"}, frm_total - base_f, exp_frm);
      check_eq({name, " ovf_err_count"}, ovf_total - base_o, exp_ovf);
      $display("%s: issues=%0d prog_done=%0d frm=%0d ovf=%0d", name, n_v, n_d,
               frm_total - base_f, ovf_total - base_o);
   endtask

   // ---------------- table of programs ----------------
   typedef struct {
      int          nb;        // bytes on the line, first byte in [47:40]
      logic [47:0] bytes;
      logic [5:0]  bad;       // bit i: byte i sent with a low stop bit
      int          busy_mode;
      int          exp_n;     // expected issues, first word in [31:24]
      logic [31:0] exp;
      int          exp_frm;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0]  w;
      logic [47:0] bytes;
      logic [31:0] ewords;
      logic [7:0]  model_q[$];
      int          n, nj;

      vecs[0] = '{5, {8'h04, 8'h04, 8'h13, 8'h86, 8'hC8, 8'h00}, 6'b000000, 0, 4, 32'h041386C8, 0};
      vecs[1] = '{5, {8'h04, 8'h04, 8'h13, 8'h86, 8'hC8, 8'h00}, 6'b000000, 3, 4, 32'h041386C8, 0};
      vecs[2] = '{3, {8'h00, 8'h01, 8'h2A, 24'h0}, 6'b000000, 0, 1, 32'h2A000000, 0};
      vecs[3] = '{3, {8'h01, 8'h55, 8'h77, 24'h0}, 6'b000010, 0, 1, 32'h77000000, 1};
      vecs[4] = '{3, {8'h02, 8'hA5, 8'h5A, 24'h0}, 6'b000000, 2, 2, 32'hA55A0000, 0};

      // Reset values
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);

      // Table-driven programs
      for (int v = 0; v < 5; v++) begin
         busy_mode = vecs[v].busy_mode;
         exp_w.delete();
         ewords = vecs[v].exp;
         for (int i = 0; i < vecs[v].exp_n; i++) exp_w.push_back(ewords[31 - 8*i -: 8]);
         exp_done = 1;
         exp_frm = vecs[v].exp_frm;
         exp_ovf = 0;
         snapshot();
         bytes = vecs[v].bytes;
         for (int i = 0; i < vecs[v].nb; i++) send_byte(bytes[47 - 8*i -: 8], !vecs[v].bad[i]);
         wait_and_check($sformatf("vec%0d", v));
      end

      // Overflow: sequencer busy for the whole download of 20 words
      busy_mode = 1;
      repeat (5) @(posedge clk);
      exp_w.delete();
      model_q.delete();
      snapshot();
      send_byte(8'h14, 1'b1);
      for (int i = 0; i < 20; i++) begin
         w = 8'($urandom);
         if (model_q.size() < DEPTH) model_q.push_back(w);
         send_byte(w, 1'b1);
      end
      repeat (20) @(negedge clk);
      check_eq("ovf issues_while_busy", vld_log.size() - base_v, 0);
      check_eq("ovf ovf_before_release", ovf_total - base_o, 20 - DEPTH);
      foreach (model_q[i]) exp_w.push_back(model_q[i]);
      exp_done = 1; exp_frm = 0; exp_ovf = 20 - DEPTH;
      busy_mode = 0;
      wait_and_check("overflow");

      // A count byte arriving before prog_done is dropped with ovf_err
      busy_mode = 1;
      repeat (5) @(posedge clk);
      snapshot();
      send_byte(8'h01, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h03, 1'b1);
      repeat (10) @(posedge clk);
      busy_mode = 0;
      exp_w.delete(); exp_w.push_back(8'hAA);
      exp_done = 1; exp_frm = 0; exp_ovf = 1;
      wait_and_check("drain_drop");
      snapshot();
      send_byte(8'h01, 1'b1);
      send_byte(8'hBB, 1'b1);
      exp_w.delete(); exp_w.push_back(8'hBB);
      exp_ovf = 0;
      wait_and_check("after_drain");

      // Reset during the data bits of the third word
      busy_mode = 1;
      repeat (5) @(posedge clk);
      snapshot();
      send_byte(8'h04, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      fork
         send_byte(8'h33, 1'b1);
         begin
            repeat (CPB * 4) @(posedge clk);
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("midreset");
         end
      join
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      busy_mode = 0;
      repeat (200) @(negedge clk);
      check_eq("midreset fifo_flushed_issues", vld_log.size() - base_v, 0);
      check_eq("midreset no_prog_done", done_log.size() - base_d, 0);
      snapshot();
      send_byte(8'h02, 1'b1);
      send_byte(8'h5C, 1'b1);
      send_byte(8'hC3, 1'b1);
      exp_w.delete(); exp_w.push_back(8'h5C); exp_w.push_back(8'hC3);
      exp_done = 1; exp_frm = 0; exp_ovf = 0;
      wait_and_check("post_reset");

      // Random programs with random busy and occasional corrupted frames
      busy_mode = 2;
      for (int p = 0; p < 3; p++) begin
         exp_w.delete();
         n = $urandom_range(1, 3);
         nj = 0;
         snapshot();
         send_byte(8'(n), 1'b1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) begin
               send_byte(8'($urandom), 1'b0);
               nj++;
            end
            w = seq_inst(2'($urandom), 6'($urandom));
            exp_w.push_back(w);
            send_byte(w, 1'b1);
         end
         exp_done = 1; exp_frm = nj; exp_ovf = 0;
         wait_and_check($sformatf("rand%0d", p));
      end
      busy_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_uart_loader.md
# seq_uart_loader

UART-to-instruction front end for the sequencer. It receives a program over the serial line as one count byte followed by that many 8-bit instruction words, buffers the words in a small FIFO, and issues them to the sequencer core one at a time on the `inst_wd`/`inst_vld` interface. This replaces switch/button instruction entry with host-driven program download, and forms the receive side that pairs with the sequencer's existing UART transmit path.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 1_000_000, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (100 at defaults)
- DEPTH, 16, instruction FIFO depth in words; must be a power of 2
- ISSUE_GAP, 4, minimum number of clk cycles from one `inst_vld` pulse to the next

- clk  in  1  system clock, all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx  in  1  serial input, 8N1, LSB first, idle high; asynchronous to clk
- inst_busy  in  1  sequencer cannot accept an instruction while high
- inst_wd  out  8  instruction word; valid only while `inst_vld` is high
- inst_vld  out  1  single-cycle issue strobe
- prog_done  out  1  single-cycle pulse after the last word of a program has been issued
- frm_err  out  1  single-cycle pulse when a stop bit is sampled low
- ovf_err  out  1  single-cycle pulse when a word arrives while the FIFO is full

## Operation
- `rx` passes through a 2-flop synchronizer. The synchronizer resets to 1.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE -> R_START on a synchronized falling edge of `rx`.
  - R_START: at count CLKS_PER_BIT/2, if `rx` = 0 go to R_DATA; otherwise it was a glitch, return to R_IDLE.
  - R_DATA: sample one bit every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample the stop bit after CLKS_PER_BIT cycles. If high, assert `byte_vld` for 1 cycle; if low, pulse `frm_err` and discard the byte. Either way return to R_IDLE.
- Loader FSM states: L_COUNT, L_LOAD, L_DRAIN.
  - L_COUNT: a received byte N loads `remain` = N. N = 0 is ignored and the FSM stays in L_COUNT. Otherwise go to L_LOAD.
  - L_LOAD: each received byte is pushed to the FIFO and decrements `remain`. When `remain` reaches 0, go to L_DRAIN.
  - If the FIFO is full, the byte is dropped, `ovf_err` pulses, and `remain` still decrements so framing with the host is preserved.
  - L_DRAIN: when the FIFO is empty and no issue is pending, pulse `prog_done` and go to L_COUNT.
- Issue logic runs in every loader state. It pops and asserts `inst_vld` for 1 cycle when all of the following hold:
  - the FIFO is not empty,
  - `inst_busy` = 0,
  - the gap counter has expired.
- Issuing a word reloads the gap counter with ISSUE_GAP-1.
- `inst_wd` holds the last issued word between strobes.
- A push and a pop in the same cycle are both allowed, including when the FIFO is full (the pop frees the slot, so no `ovf_err`).
- Bytes received while in L_DRAIN are treated as the next program's count byte only after `prog_done`. Before that they are dropped and `ovf_err` pulses.
- Reset mid-frame or mid-program aborts everything: the FIFO is flushed and both FSMs return to their idle states.

## Timing
- Reset values:
  - `inst_wd` = 8'h00
  - `inst_vld`, `prog_done`, `frm_err`, `ovf_err` = 0
  - RX FSM in R_IDLE, loader FSM in L_COUNT, FIFO empty, gap counter = 0
- Start-edge detect to first data sample: 2 (synchronizer) + CLKS_PER_BIT/2 + CLKS_PER_BIT cycles.
- Stop-bit sample -> `byte_vld`: same cycle. `byte_vld` -> FIFO write: +1 cycle. FIFO non-empty -> `inst_vld`: +1 cycle at the earliest.
- `inst_busy` is sampled in the same cycle as the issue decision; there is no skid.
- Inter-issue spacing is at least ISSUE_GAP cycles, and longer while `inst_busy` stays high.
- `prog_done` asserts 1 cycle after the final `inst_vld`, provided the FIFO is empty.

## Structure
- Sub-module `uart_rx_core`: the synchronizer, the RX FSM and the baud counter, with outputs `byte_wd[7:0]`, `byte_vld` and `frm_err`.
- The FIFO is inline: DEPTH entries, pointers of width log2(DEPTH)+1 so the extra MSB distinguishes full from empty.
- Add to `seq_definitions.v`:
  - RX state encodings and loader state encodings,
  - the default BAUD,
  - the `seq_op_*` opcodes, used by the bench only.

## Test plan
- Send 0x04 then 0x04, 0x13, 0x86, 0xC8 at 1 Mbaud with `inst_busy` = 0 -> four `inst_vld` pulses carrying 0x04, 0x13, 0x86, 0xC8 in order, ≥4 cycles apart, then one `prog_done` pulse.
- Same program with `inst_busy` held high for 10 µs after each issue -> the next `inst_vld` comes no earlier than 1 cycle after `inst_busy` falls, and word order is unchanged.
- Byte 0x55 framed with stop bit = 0 -> one `frm_err` pulse, no FIFO push, `remain` unchanged.
- `inst_busy` = 1 throughout, count 0x14, 20 words -> 16 words buffered, 4 `ovf_err` pulses; release busy -> exactly 16 issues, then `prog_done`.
- Count byte 0x00 -> no state change; the next byte 0x01 followed by 0x2A -> a single issue of 0x2A.
- Assert `rst_n` low during the data bits of the third word -> all outputs are at reset values immediately, the FIFO is empty, and a fresh program afterwards executes correctly.
